// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared FSM state encoding and port identifiers for mem_arbiter
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_ACK   = 2'd3
   } state_t;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rtl/mem_arbiter_rr_pick.sv - two-way round-robin / fixed-priority request select
module mem_arbiter_rr_pick
   import mem_arbiter_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_last,
   input  logic       i_excl_en,
   input  logic       i_excl_id,
   input  logic       i_prio,
   output logic       o_valid,
   output logic       o_id
);

   logic [1:0] w_mask;
   logic [1:0] w_eff;

   always_comb begin
      w_mask = 2'b11;
      // In priority mode the CPU is never excluded, so a CPU holding req keeps the memory.
      if (i_excl_en && !(i_prio && (i_excl_id == PORT_CPU))) begin
         w_mask[i_excl_id] = 1'b0;
      end
      w_eff   = i_req & w_mask;
      o_valid = |w_eff;
      if (i_prio && w_eff[0]) begin
         o_id = PORT_CPU;
      end else if (&w_eff) begin
         o_id = ~i_last;
      end else begin
         o_id = w_eff[1] && !w_eff[0];
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - per-transaction arbiter sharing one unified memory between CPU and loader
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int AW           = 6,
   parameter int DW           = 32,
   parameter int RD_LAT       = 1,
   parameter int CPU_PRIORITY = 0
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_req0,
   input  logic          i_we0,
   input  logic [AW-1:0] i_addr0,
   input  logic [DW-1:0] i_wdata0,
   input  logic          i_req1,
   input  logic          i_we1,
   input  logic [AW-1:0] i_addr1,
   input  logic [DW-1:0] i_wdata1,
   output logic          o_ack0,
   output logic          o_ack1,
   output logic [DW-1:0] o_rdata0,
   output logic [DW-1:0] o_rdata1,
   output logic          o_mem_en,
   output logic          o_mem_we,
   output logic [AW-1:0] o_mem_addr,
   output logic [DW-1:0] o_mem_wdata,
   input  logic [DW-1:0] i_mem_rdata,
   output logic          o_busy,
   output logic          o_gnt_id
);

   localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

   state_t        r_state;
   state_t        w_next;
   logic          r_gnt;
   logic          r_last;
   logic          r_we;
   logic [2:0]    r_cnt;
   logic [DW-1:0] r_rdata0;
   logic [DW-1:0] r_rdata1;

   logic          w_pick_valid;
   logic          w_pick_id;
   logic          w_sel_we;
   logic [AW-1:0] w_sel_addr;
   logic [DW-1:0] w_sel_wdata;
   logic          w_ack;

   assign w_sel_we    = (r_gnt == PORT_LDR) ? i_we1    : i_we0;
   assign w_sel_addr  = (r_gnt == PORT_LDR) ? i_addr1  : i_addr0;
   assign w_sel_wdata = (r_gnt == PORT_LDR) ? i_wdata1 : i_wdata0;

   // In ACK the finishing port still has req high, so it is excluded from re-arbitration.
   mem_arbiter_rr_pick u_pick (
      .i_req     ({i_req1, i_req0}),
      .i_last    (r_last),
      .i_excl_en (r_state == ST_ACK),
      .i_excl_id (r_gnt),
      .i_prio    (CPU_PRIORITY != 0),
      .o_valid   (w_pick_valid),
      .o_id      (w_pick_id)
   );

   always_comb begin
      w_next      = r_state;
      o_mem_en    = 1'b0;
      o_mem_we    = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_pick_valid) w_next = ST_ISSUE;
         end
         ST_ISSUE: begin
            o_mem_en    = 1'b1;
            o_mem_we    = w_sel_we;
            o_mem_addr  = w_sel_addr;
            o_mem_wdata = w_sel_wdata;
            if (w_sel_we || (RD_LAT == 1)) w_next = ST_ACK;
            else                           w_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (r_cnt == 3'd1) w_next = ST_ACK;
         end
         ST_ACK: begin
            w_next = w_pick_valid ? ST_ISSUE : ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state  <= ST_IDLE;
         r_gnt    <= PORT_CPU;
         r_last   <= PORT_LDR;
         r_we     <= 1'b0;
         r_cnt    <= 3'd0;
         r_rdata0 <= '0;
         r_rdata1 <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            ST_IDLE: begin
               if (w_pick_valid) r_gnt <= w_pick_id;
            end
            ST_ISSUE: begin
               r_we  <= w_sel_we;
               r_cnt <= CNT_INIT;
            end
            ST_WAIT: begin
               r_cnt <= r_cnt - 3'd1;
            end
            ST_ACK: begin
               r_last <= r_gnt;
               if (!r_we && (r_gnt == PORT_CPU)) r_rdata0 <= i_mem_rdata;
               if (!r_we && (r_gnt == PORT_LDR)) r_rdata1 <= i_mem_rdata;
               if (w_pick_valid) r_gnt <= w_pick_id;
            end
            default: ;
         endcase
      end
   end

   assign w_ack    = (r_state == ST_ACK);
   assign o_ack0   = w_ack && (r_gnt == PORT_CPU);
   assign o_ack1   = w_ack && (r_gnt == PORT_LDR);
   assign o_rdata0 = (o_ack0 && !r_we) ? i_mem_rdata : r_rdata0;
   assign o_rdata1 = (o_ack1 && !r_we) ? i_mem_rdata : r_rdata1;
   assign o_busy   = (r_state != ST_IDLE);
   assign o_gnt_id = r_gnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter in RR, priority and long-latency configs
module tb_mem_arbiter;

   localparam logic [31:0] V5 = 32'hE3A0_0001;
   localparam logic [31:0] VC = 32'hCAFE_0006;
   localparam logic [31:0] VB = 32'hDEAD_BEEF;
   localparam logic [31:0] Z  = 32'h0;

   logic        clk;
   logic [2:0]  rst, req0, we0, req1, we1;
   logic [5:0]  addr0 [3];
   logic [5:0]  addr1 [3];
   logic [31:0] wdata0 [3];
   logic [31:0] wdata1 [3];
   logic [2:0]  ack0, ack1, mem_en, mem_we, busy, gnt;
   logic [5:0]  mem_addr [3];
   logic [31:0] mem_wdata [3];
   logic [31:0] mem_rdata [3];
   logic [31:0] rdata0 [3];
   logic [31:0] rdata1 [3];
   logic [107:0] out_vec [3];

   int n_run  = 0;
   int n_fail = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instance 0: round-robin, RD_LAT=1; 1: CPU priority, RD_LAT=1; 2: round-robin, RD_LAT=3.
   for (genvar g = 0; g < 3; g++) begin : g_inst
      localparam int LAT  = (g == 2) ? 3 : 1;
      localparam int PRIO = (g == 1) ? 1 : 0;
      logic [31:0] ram [64];
      logic [31:0] pipe [LAT];

      always @(posedge clk) begin
         if (rst[g]) begin
            ram[5] <= V5;
            ram[6] <= VC;
         end else if (mem_en[g] && mem_we[g]) begin
            ram[mem_addr[g]] <= mem_wdata[g];
         end
         pipe[0] <= (mem_en[g] && !mem_we[g]) ? ram[mem_addr[g]] : 32'h0BAD_0BAD;
         for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
      end
      assign mem_rdata[g] = pipe[LAT-1];

      mem_arbiter #(.AW(6), .DW(32), .RD_LAT(LAT), .CPU_PRIORITY(PRIO)) u_dut (
         .i_clk       (clk),
         .i_reset     (rst[g]),
         .i_req0      (req0[g]),
         .i_we0       (we0[g]),
         .i_addr0     (addr0[g]),
         .i_wdata0    (wdata0[g]),
         .i_req1      (req1[g]),
         .i_we1       (we1[g]),
         .i_addr1     (addr1[g]),
         .i_wdata1    (wdata1[g]),
         .o_ack0      (ack0[g]),
         .o_ack1      (ack1[g]),
         .o_rdata0    (rdata0[g]),
         .o_rdata1    (rdata1[g]),
         .o_mem_en    (mem_en[g]),
         .o_mem_we    (mem_we[g]),
         .o_mem_addr  (mem_addr[g]),
         .o_mem_wdata (mem_wdata[g]),
         .i_mem_rdata (mem_rdata[g]),
         .o_busy      (busy[g]),
         .o_gnt_id    (gnt[g])
      );

      assign out_vec[g] = {ack0[g], ack1[g], mem_en[g], mem_we[g], busy[g], gnt[g],
                           mem_addr[g], mem_wdata[g], rdata0[g], rdata1[g]};
   end

   // flags = {ack0, ack1, mem_en, mem_we, busy, gnt_id}
   function automatic logic [107:0] po(input logic [5:0] flags, input logic [5:0] ad,
                                       input logic [31:0] wd, input logic [31:0] r0,
                                       input logic [31:0] r1);
      return {flags, ad, wd, r0, r1};
   endfunction

   task automatic chk(input string nm, input logic [107:0] act, input logic [107:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [4:0]   fin;   // {rst, req0, we0, req1, we1}
      logic [5:0]   a0;
      logic [31:0]  d0;
      logic [5:0]   a1;
      logic [31:0]  d1;
      logic [107:0] exp;
   } vec_t;

   vec_t tv[$];

   task automatic add(input logic [4:0] fin, input logic [5:0] a0, input logic [31:0] d0,
                      input logic [5:0] a1, input logic [31:0] d1, input logic [107:0] exp);
      vec_t v;
      v.fin = fin; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1; v.exp = exp;
      tv.push_back(v);
   endtask

   logic [107:0] bexp [8];
   logic [107:0] cexp [12];

   initial begin
      rst = 3'b111; req0 = 3'b111; we0 = 3'b000; req1 = 3'b000; we1 = 3'b000;
      for (int g = 0; g < 3; g++) begin
         addr0[g] = 6'd5; addr1[g] = 6'd0; wdata0[g] = Z; wdata1[g] = Z;
      end

      // Port0 read, port1 write then port0 read-back, reset, simultaneous requests.
      add(5'b01000, 6'd5, Z, 6'd0, Z,  po(6'b000000, 6'd0, Z, Z,  Z));
      add(5'b01000, 6'd5, Z, 6'd0, Z,  po(6'b001010, 6'd5, Z, Z,  Z));
      add(5'b01000, 6'd5, Z, 6'd0, Z,  po(6'b100010, 6'd0, Z, V5, Z));
      add(5'b00000, 6'd0, Z, 6'd0, Z,  po(6'b000000, 6'd0, Z, V5, Z));
      add(5'b00000, 6'd0, Z, 6'd0, Z,  po(6'b000000, 6'd0, Z, V5, Z));
      add(5'b00000, 6'd0, Z, 6'd0, Z,  po(6'b000000, 6'd0, Z, V5, Z));
      add(5'b00011, 6'd0, Z, 6'd6, VB, po(6'b000000, 6'd0, Z, V5, Z));
      add(5'b00011, 6'd0, Z, 6'd6, VB, po(6'b001111, 6'd6, VB, V5, Z));
      add(5'b00011, 6'd0, Z, 6'd6, VB, po(6'b010011, 6'd0, Z, V5, Z));
      add(5'b01000, 6'd6, Z, 6'd0, Z,  po(6'b000001, 6'd0, Z, V5, Z));
      add(5'b01000, 6'd6, Z, 6'd0, Z,  po(6'b001010, 6'd6, Z, V5, Z));
      add(5'b01000, 6'd6, Z, 6'd0, Z,  po(6'b100010, 6'd0, Z, VB, Z));
      add(5'b00000, 6'd0, Z, 6'd0, Z,  po(6'b000000, 6'd0, Z, VB, Z));
      add(5'b10000, 6'd0, Z, 6'd0, Z,  po(6'b000000, 6'd0, Z, VB, Z));
      add(5'b01010, 6'd5, Z, 6'd6, Z,  po(6'b000000, 6'd0, Z, Z,  Z));
      add(5'b01010, 6'd5, Z, 6'd6, Z,  po(6'b001010, 6'd5, Z, Z,  Z));
      add(5'b01010, 6'd5, Z, 6'd6, Z,  po(6'b100010, 6'd0, Z, V5, Z));
      add(5'b01010, 6'd5, Z, 6'd6, Z,  po(6'b001011, 6'd6, Z, V5, Z));
      add(5'b01010, 6'd5, Z, 6'd6, Z,  po(6'b010011, 6'd0, Z, V5, VC));
      add(5'b01000, 6'd5, Z, 6'd0, Z,  po(6'b001010, 6'd5, Z, V5, VC));
      add(5'b01000, 6'd5, Z, 6'd0, Z,  po(6'b100010, 6'd0, Z, V5, VC));
      add(5'b00000, 6'd0, Z, 6'd0, Z,  po(6'b000000, 6'd0, Z, V5, VC));

      bexp[0] = po(6'b000000, 6'd0, Z, Z,  Z);
      bexp[1] = po(6'b001010, 6'd5, Z, Z,  Z);
      bexp[2] = po(6'b100010, 6'd0, Z, V5, Z);
      bexp[3] = po(6'b001010, 6'd5, Z, V5, Z);
      bexp[4] = po(6'b100010, 6'd0, Z, V5, Z);
      bexp[5] = po(6'b001011, 6'd6, Z, V5, Z);
      bexp[6] = po(6'b010011, 6'd0, Z, V5, VC);
      bexp[7] = po(6'b000001, 6'd0, Z, V5, VC);

      cexp[0]  = po(6'b000000, 6'd0, Z, Z,  Z);
      cexp[1]  = po(6'b001010, 6'd5, Z, Z,  Z);
      cexp[2]  = po(6'b000010, 6'd0, Z, Z,  Z);
      cexp[3]  = po(6'b000010, 6'd0, Z, Z,  Z);
      cexp[4]  = po(6'b100010, 6'd0, Z, V5, Z);
      cexp[5]  = po(6'b000000, 6'd0, Z, V5, Z);
      cexp[6]  = po(6'b000000, 6'd0, Z, V5, Z);
      cexp[7]  = po(6'b001010, 6'd5, Z, V5, Z);
      cexp[8]  = po(6'b000010, 6'd0, Z, V5, Z);
      cexp[9]  = po(6'b000010, 6'd0, Z, V5, Z);
      cexp[10] = po(6'b000000, 6'd0, Z, Z,  Z);
      cexp[11] = po(6'b000000, 6'd0, Z, Z,  Z);

      // Reset held two cycles with req0 high: every output stays zero.
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         #1;
         for (int g = 0; g < 3; g++)
            chk($sformatf("reset inst%0d cyc%0d", g, c), out_vec[g], 108'd0);
      end

      foreach (tv[i]) begin
         @(negedge clk);
         {rst[0], req0[0], we0[0], req1[0], we1[0]} = tv[i].fin;
         addr0[0] = tv[i].a0; wdata0[0] = tv[i].d0;
         addr1[0] = tv[i].a1; wdata1[0] = tv[i].d1;
         #1;
         chk($sformatf("rr row %0d", i), out_vec[0], tv[i].exp);
      end

      // CPU priority: held req0 starves port1 until it drops in an ACK cycle.
      addr0[1] = 6'd5; addr1[1] = 6'd6;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         rst[1]  = 1'b0;
         req0[1] = (c < 4);
         req1[1] = (c < 7);
         #1;
         chk($sformatf("prio cyc %0d", c), out_vec[1], bexp[c]);
      end

      // RD_LAT=3: two WAIT cycles, then a second read aborted by reset in WAIT.
      addr0[2] = 6'd5;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         rst[2]  = (c == 9);
         req0[2] = (c < 5) || ((c >= 6) && (c < 10));
         #1;
         chk($sformatf("lat3 cyc %0d", c), out_vec[2], cexp[c]);
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
